// File: rtl/mbtrain_pkg.sv
// Shared MBTRAIN sideband definitions: arbiter state encoding, message codes and grant indices.
package mbtrain_pkg;

   localparam int unsigned MSG_W  = 4;
   localparam int unsigned GNT_W  = 2;
   localparam int unsigned GNT_TX = 0;
   localparam int unsigned GNT_RX = 1;

   localparam logic [MSG_W-1:0] MSG_START_REQ  = MSG_W'(1);
   localparam logic [MSG_W-1:0] MSG_START_RESP = MSG_W'(2);
   localparam logic [MSG_W-1:0] MSG_END_REQ    = MSG_W'(3);
   localparam logic [MSG_W-1:0] MSG_END_RESP   = MSG_W'(4);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT_BUSY_RISE,
      ST_WAIT_BUSY_FALL,
      ST_RELEASE
   } sb_arb_state_e;

   // One-hot grant vector for the chosen owner.
   function automatic logic [GNT_W-1:0] grant_onehot(input logic rx_owner);
      grant_onehot = rx_owner ? GNT_W'(1 << GNT_RX) : GNT_W'(1 << GNT_TX);
   endfunction

endpackage

// File: rtl/sb_busy_edge_det.sv
// Registers the sideband-encoder busy flag and flags its rising and falling edges.
module sb_busy_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic busy_i,
   output logic rise_c_o,
   output logic fall_c_o
);

   logic busy_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
      end else begin
         busy_q <= busy_i;
      end
   end

   assign rise_c_o = busy_i & ~busy_q;
   assign fall_c_o = busy_q & ~busy_i;

endmodule

// File: rtl/mbtrain_sb_arbiter.sv
// Round-robin owner of the MBTRAIN sideband TX slot shared by the TX- and RX-side step FSMs.
// Optional busy-wait timeout enabled by defining MBTRAIN_SB_ARB_TIMEOUT_EN.
module mbtrain_sb_arbiter
   import mbtrain_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter int unsigned CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_en,
   input  logic             i_valid_tx,
   input  logic [MSG_W-1:0] i_msg_tx,
   input  logic             i_valid_rx,
   input  logic [MSG_W-1:0] i_msg_rx,
   input  logic             i_sb_busy,
   output logic             o_sb_valid,
   output logic [MSG_W-1:0] o_sb_message,
   output logic [GNT_W-1:0] o_grant,
   output logic             o_busy_negedge_detected,
   output logic             o_timeout
);

   sb_arb_state_e    state_q, state_d;
   logic             sb_valid_q, sb_valid_d;
   logic [MSG_W-1:0] sb_msg_q, sb_msg_d;
   logic [GNT_W-1:0] grant_q, grant_d;
   logic             pulse_q, pulse_d;
   logic             last_rx_q, last_rx_d;
   logic             pick_rx_c;
   logic             busy_rise_c;
   logic             busy_fall_c;
   logic             wait_hit_c;

   sb_busy_edge_det u_busy_edge (
      .clk      (clk),
      .rst_n    (rst_n),
      .busy_i   (i_sb_busy),
      .rise_c_o (busy_rise_c),
      .fall_c_o (busy_fall_c)
   );

   // Next state and registered outputs; outputs are computed for the state being entered.
   always_comb begin
      state_d    = state_q;
      sb_valid_d = 1'b0;
      sb_msg_d   = sb_msg_q;
      grant_d    = grant_q;
      pulse_d    = 1'b0;
      last_rx_d  = last_rx_q;
      pick_rx_c  = i_valid_rx & (~i_valid_tx | ~last_rx_q);
      if (!i_en) begin
         state_d  = ST_IDLE;
         sb_msg_d = '0;
         grant_d  = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if ((i_valid_tx | i_valid_rx) & ~i_sb_busy) begin
                  state_d    = ST_LAUNCH;
                  sb_valid_d = 1'b1;
                  sb_msg_d   = pick_rx_c ? i_msg_rx : i_msg_tx;
                  grant_d    = grant_onehot(pick_rx_c);
               end
            end
            ST_LAUNCH:         state_d = ST_WAIT_BUSY_RISE;
            ST_WAIT_BUSY_RISE: if (busy_rise_c | i_sb_busy) state_d = ST_WAIT_BUSY_FALL;
            ST_WAIT_BUSY_FALL: if (busy_fall_c) state_d = ST_RELEASE;
            ST_RELEASE: begin
               state_d   = ST_IDLE;
               last_rx_d = grant_q[GNT_RX];
               grant_d   = '0;
               sb_msg_d  = '0;
            end
            default:           state_d = ST_IDLE;
         endcase
         if (wait_hit_c) state_d = ST_RELEASE;
         pulse_d = (state_d == ST_RELEASE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         sb_valid_q <= 1'b0;
         sb_msg_q   <= '0;
         grant_q    <= '0;
         pulse_q    <= 1'b0;
         last_rx_q  <= 1'b1;
      end else begin
         state_q    <= state_d;
         sb_valid_q <= sb_valid_d;
         sb_msg_q   <= sb_msg_d;
         grant_q    <= grant_d;
         pulse_q    <= pulse_d;
         last_rx_q  <= last_rx_d;
      end
   end

`ifdef MBTRAIN_SB_ARB_TIMEOUT_EN
   localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYC);

   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_c;
   logic             waiting_c;
   logic             en_q;
   logic             timeout_q, timeout_d;

   // Saturating busy-wait counter; the timeout fires on the cycle the count reaches the limit.
   always_comb begin
      waiting_c  = (state_q == ST_WAIT_BUSY_RISE) | (state_q == ST_WAIT_BUSY_FALL);
      cnt_inc_c  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
      wait_hit_c = i_en & waiting_c & (cnt_inc_c >= CNT_LIM);
      cnt_d      = cnt_q;
      if (state_q == ST_LAUNCH) begin
         cnt_d = '0;
      end else if (waiting_c) begin
         cnt_d = cnt_inc_c;
      end
      timeout_d = timeout_q;
      if (i_en & ~en_q) begin
         timeout_d = 1'b0;
      end else if (wait_hit_c) begin
         timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         en_q      <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         en_q      <= i_en;
         timeout_q <= timeout_d;
      end
   end

   assign o_timeout = timeout_q;
`else
   // Parameters only size the optional timeout counter.
   logic unused_cfg_c;
   assign unused_cfg_c = ^{TIMEOUT_CYC, CNT_W};
   assign wait_hit_c   = 1'b0;
   assign o_timeout    = 1'b0;
`endif

   assign o_sb_valid              = sb_valid_q;
   assign o_sb_message            = sb_msg_q;
   assign o_grant                 = grant_q;
   assign o_busy_negedge_detected = pulse_q;

endmodule

// File: tb/tb_mbtrain_sb_arbiter.sv
// Directed bench for mbtrain_sb_arbiter: arbitration order, launch/completion timing, abort and timeout.
module tb_mbtrain_sb_arbiter;
   import mbtrain_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             i_en;
   logic             i_valid_tx;
   logic [MSG_W-1:0] i_msg_tx;
   logic             i_valid_rx;
   logic [MSG_W-1:0] i_msg_rx;
   logic             i_sb_busy;
   logic             o_sb_valid;
   logic [MSG_W-1:0] o_sb_message;
   logic [GNT_W-1:0] o_grant;
   logic             o_busy_negedge_detected;
   logic             o_timeout;

   int unsigned n_checks   = 0;
   int unsigned n_errors   = 0;
   int unsigned cyc        = 0;
   int unsigned launch_cyc = 0;
   bit          have_launch = 1'b0;

   always #5 clk = ~clk;

   mbtrain_sb_arbiter #(.TIMEOUT_CYC(8), .CNT_W(8)) dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .i_en                    (i_en),
      .i_valid_tx              (i_valid_tx),
      .i_msg_tx                (i_msg_tx),
      .i_valid_rx              (i_valid_rx),
      .i_msg_rx                (i_msg_rx),
      .i_sb_busy               (i_sb_busy),
      .o_sb_valid              (o_sb_valid),
      .o_sb_message            (o_sb_message),
      .o_grant                 (o_grant),
      .o_busy_negedge_detected (o_busy_negedge_detected),
      .o_timeout               (o_timeout)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic apply_reset();
      i_valid_tx = 1'b0;
      i_valid_rx = 1'b0;
      i_sb_busy  = 1'b0;
      i_en       = 1'b1;
      rst_n      = 1'b0;
      tick();
      tick();
      check_eq("rst sb_valid", 32'(o_sb_valid), 32'd0);
      check_eq("rst message",  32'(o_sb_message), 32'd0);
      check_eq("rst grant",    32'(o_grant), 32'd0);
      check_eq("rst pulse",    32'(o_busy_negedge_detected), 32'd0);
      check_eq("rst timeout",  32'(o_timeout), 32'd0);
      rst_n = 1'b1;
   endtask

   // One transaction with busy high for cycles 3..6 after launch; pulse expected at cycle 8.
   task automatic do_txn(input string tag, input logic [1:0] exp_gnt,
                         input logic [MSG_W-1:0] exp_msg, input bit keep);
      int unsigned waited = 0;
      while (o_sb_valid !== 1'b1 && waited < 20) begin
         tick();
         waited++;
      end
      check_eq({tag, " launch"}, 32'(o_sb_valid), 32'd1);
      check_eq({tag, " msg"},    32'(o_sb_message), 32'(exp_msg));
      check_eq({tag, " grant"},  32'(o_grant), 32'(exp_gnt));
      if (have_launch) check_eq({tag, " spacing"}, 32'((cyc - launch_cyc) >= 5), 32'd1);
      launch_cyc  = cyc;
      have_launch = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (c == 3) i_sb_busy = 1'b1;
         if (c == 7) i_sb_busy = 1'b0;
         check_eq({tag, " pulse"},  32'(o_busy_negedge_detected), 32'(c == 8));
         check_eq({tag, " single"}, 32'(o_sb_valid), 32'd0);
      end
      check_eq({tag, " owner"}, 32'(o_grant), 32'(exp_gnt));
      tick();
      if (!keep) begin
         if (exp_gnt[GNT_RX]) i_valid_rx = 1'b0;
         else                 i_valid_tx = 1'b0;
      end
      check_eq({tag, " rel grant"}, 32'(o_grant), 32'd0);
      check_eq({tag, " rel msg"},   32'(o_sb_message), 32'd0);
      check_eq({tag, " rel pulse"}, 32'(o_busy_negedge_detected), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int unsigned waited;
      int unsigned busy_low_cyc;
      i_msg_tx = '0;
      i_msg_rx = '0;
      apply_reset();

      // TX-only request.
      i_msg_tx   = MSG_START_REQ;
      i_valid_tx = 1'b1;
      do_txn("tx_only", 2'b01, MSG_START_REQ, 1'b0);

      // Tie from reset: TX first, then RX.
      apply_reset();
      i_msg_tx   = MSG_START_REQ;
      i_msg_rx   = MSG_START_RESP;
      i_valid_tx = 1'b1;
      i_valid_rx = 1'b1;
      do_txn("tie_tx", 2'b01, MSG_START_REQ, 1'b0);
      do_txn("tie_rx", 2'b10, MSG_START_RESP, 1'b0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check_eq("tie no relaunch", 32'(o_sb_valid), 32'd0);
      end

      // Three back-to-back tie rounds with both valids held.
      i_msg_tx   = MSG_END_REQ;
      i_msg_rx   = MSG_END_RESP;
      i_valid_tx = 1'b1;
      i_valid_rx = 1'b1;
      for (int r = 0; r < 3; r++) begin
         do_txn($sformatf("rr%0d_tx", r), 2'b01, MSG_END_REQ, 1'b1);
         do_txn($sformatf("rr%0d_rx", r), 2'b10, MSG_END_RESP, 1'b1);
      end
      i_valid_tx = 1'b0;
      i_valid_rx = 1'b0;

      // Abort in WAIT_BUSY_FALL, then re-enable.
      i_msg_rx   = MSG_START_RESP;
      i_valid_rx = 1'b1;
      waited = 0;
      while (o_sb_valid !== 1'b1 && waited < 20) begin
         tick();
         waited++;
      end
      check_eq("abort launch", 32'(o_sb_valid), 32'd1);
      check_eq("abort grant",  32'(o_grant), 32'd2);
      launch_cyc = cyc;
      tick();
      tick();
      tick();
      i_sb_busy = 1'b1;
      tick();
      tick();
      i_en = 1'b0;
      tick();
      i_sb_busy = 1'b0;
      check_eq("abort grant0", 32'(o_grant), 32'd0);
      check_eq("abort msg0",   32'(o_sb_message), 32'd0);
      check_eq("abort valid0", 32'(o_sb_valid), 32'd0);
      check_eq("abort pulse",  32'(o_busy_negedge_detected), 32'd0);
      tick();
      check_eq("abort pulse2", 32'(o_busy_negedge_detected), 32'd0);
      check_eq("abort idle",   32'(o_sb_valid), 32'd0);
      i_en = 1'b1;
      do_txn("reen_rx", 2'b10, MSG_START_RESP, 1'b0);

      // Request while the encoder is busy.
      i_sb_busy  = 1'b1;
      i_msg_tx   = MSG_END_REQ;
      i_valid_tx = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check_eq("busy hold", 32'(o_sb_valid), 32'd0);
      end
      i_sb_busy    = 1'b0;
      busy_low_cyc = cyc;
      do_txn("busy_pend", 2'b01, MSG_END_REQ, 1'b0);
      check_eq("busy latency", 32'((launch_cyc - busy_low_cyc) <= 2), 32'd1);

      // Busy never rises.
      i_msg_tx   = MSG_END_RESP;
      i_valid_tx = 1'b1;
      waited = 0;
      while (o_sb_valid !== 1'b1 && waited < 20) begin
         tick();
         waited++;
      end
      check_eq("to launch", 32'(o_sb_valid), 32'd1);
      for (int c = 1; c <= 12; c++) begin
         tick();
`ifdef MBTRAIN_SB_ARB_TIMEOUT_EN
         check_eq("to pulse",   32'(o_busy_negedge_detected), 32'(c == 9));
         check_eq("to flag",    32'(o_timeout), 32'(c >= 9));
         check_eq("to grant",   32'(o_grant), (c <= 9) ? 32'd1 : 32'd0);
         if (c == 10) i_valid_tx = 1'b0;
`else
         check_eq("stuck pulse", 32'(o_busy_negedge_detected), 32'd0);
         check_eq("stuck flag",  32'(o_timeout), 32'd0);
         check_eq("stuck grant", 32'(o_grant), 32'd1);
`endif
      end
      i_en       = 1'b0;
      i_valid_tx = 1'b0;
      tick();
      check_eq("to abort grant", 32'(o_grant), 32'd0);
`ifdef MBTRAIN_SB_ARB_TIMEOUT_EN
      check_eq("to sticky", 32'(o_timeout), 32'd1);
`else
      check_eq("to sticky", 32'(o_timeout), 32'd0);
`endif
      i_en = 1'b1;
      tick();
      check_eq("to cleared", 32'(o_timeout), 32'd0);
      check_eq("to no launch", 32'(o_sb_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
